// File: rtl/drum_motor_sequencer.sv
// Drum motor speed sequencer: one wash/rinse/spin phase per command.
// Ramps the 4-bit speed up, holds it for a number of ticks (with optional
// direction reversals), then ramps down. It also handles rebalancing,
// door-unlock faults and controlled aborts.
module drum_motor_sequencer #(
  parameter int TICK_DIV    = 1000,
  parameter int REV_TICKS   = 15,
  parameter int PAUSE_TICKS = 2,
  parameter int REBAL_TICKS = 4,
  parameter int MAX_REBAL   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_speed_i,
  input  logic [9:0] cmd_ticks_i,
  input  logic       cmd_agitate_i,
  input  logic       abort_i,
  input  logic       door_locked_i,
  input  logic       vibration_i,
  input  logic       fault_clr_i,
  output logic [3:0] motor_speed_o,
  output logic       motor_dir_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       aborted_o,
  output logic       fault_o
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW   = $clog2(REV_TICKS + 1);
  localparam int HOLD = (PAUSE_TICKS > REBAL_TICKS) ? PAUSE_TICKS : REBAL_TICKS;
  localparam int HW   = $clog2(HOLD + 1);
  localparam int BW   = $clog2(MAX_REBAL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP_UP, S_RUN, S_PAUSE, S_REBAL, S_RAMP_DOWN, S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      speed_q, speed_d, tgt_q, tgt_d;
  logic [9:0]      run_q, run_d;
  logic [RW-1:0]   rev_q, rev_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   rebal_q, rebal_d;
  logic            agit_q, agit_d, dir_q, dir_d, abt_q, abt_d;
  logic            done_q, done_d, aborted_q, aborted_d;
  logic            fault_q, fault_d, busy_q, busy_d;

  logic       tick, accept, zero_cmd, door_ev, abort_ev, vib_ev;
  logic [3:0] speed_up;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign accept   = cmd_valid_i & cmd_ready_o;
  assign zero_cmd = (cmd_speed_i == 4'd0) | (cmd_ticks_i == 10'd0);
  // FAULT itself is exempt so fault_clr can leave it with the door still open
  assign door_ev  = ~door_locked_i & (state_q != S_IDLE) & (state_q != S_FAULT);
  assign abort_ev = abort_i & ((state_q == S_RAMP_UP) | (state_q == S_RUN) |
                               (state_q == S_PAUSE) | (state_q == S_REBAL));
  assign vib_ev   = vibration_i & ((state_q == S_RAMP_UP) | (state_q == S_RUN));
  assign speed_up = (speed_q < tgt_q) ? speed_q + 4'd1 : speed_q;

  assign cmd_ready_o   = (state_q == S_IDLE) & door_locked_i & ~fault_q;
  assign motor_speed_o = speed_q;
  assign motor_dir_o   = dir_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign fault_o       = fault_q;

  // State and datapath registers, async active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      speed_q   <= '0;
      tgt_q     <= '0;
      run_q     <= '0;
      rev_q     <= '0;
      hold_q    <= '0;
      rebal_q   <= '0;
      agit_q    <= 1'b0;
      dir_q     <= 1'b0;
      abt_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      speed_q   <= speed_d;
      tgt_q     <= tgt_d;
      run_q     <= run_d;
      rev_q     <= rev_d;
      hold_q    <= hold_d;
      rebal_q   <= rebal_d;
      agit_q    <= agit_d;
      dir_q     <= dir_d;
      abt_q     <= abt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: door > abort > vibration > tick-driven progress
  always_comb begin
    state_d = state_q;
    if (door_ev)       state_d = S_FAULT;
    else if (abort_ev) state_d = S_RAMP_DOWN;
    else if (vib_ev)   state_d = (rebal_q == BW'(MAX_REBAL)) ? S_FAULT : S_REBAL;
    else begin
      case (state_q)
        S_IDLE:      if (accept && !zero_cmd) state_d = S_RAMP_UP;
        S_RAMP_UP:   if (tick && speed_up == tgt_q) state_d = S_RUN;
        S_RUN: if (tick) begin
          // hold expiry wins over a reversal due on the same tick
          if (run_q <= 10'd1)                    state_d = S_RAMP_DOWN;
          else if (agit_q && rev_q <= RW'(1))    state_d = S_PAUSE;
        end
        S_PAUSE:     if (tick && hold_q <= HW'(1)) state_d = S_RAMP_UP;
        S_REBAL:     if (tick && hold_q <= HW'(1)) state_d = S_RAMP_UP;
        S_RAMP_DOWN: if (tick && speed_q <= 4'd1) state_d = S_IDLE;
        S_FAULT:     if (fault_clr_i) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs and counters for the coming cycle
  always_comb begin
    presc_d   = (accept || tick) ? '0 : presc_q + PW'(1);
    speed_d   = speed_q;
    tgt_d     = tgt_q;
    run_d     = run_q;
    rev_d     = rev_q;
    hold_d    = hold_q;
    rebal_d   = rebal_q;
    agit_d    = agit_q;
    dir_d     = dir_q;
    abt_d     = abt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    fault_d   = (state_d == S_FAULT);
    if (door_ev) begin
      speed_d = 4'd0;
    end else if (abort_ev) begin
      abt_d = 1'b1;
    end else if (vib_ev) begin
      speed_d = (rebal_q == BW'(MAX_REBAL)) ? 4'd0 : 4'd1;
      rebal_d = (rebal_q == BW'(MAX_REBAL)) ? rebal_q : rebal_q + BW'(1);
      hold_d  = HW'(REBAL_TICKS);
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          tgt_d   = cmd_speed_i;
          run_d   = cmd_ticks_i;
          agit_d  = cmd_agitate_i;
          dir_d   = 1'b0;
          rebal_d = '0;
          abt_d   = 1'b0;
          speed_d = 4'd0;
          done_d  = zero_cmd;
        end
        S_RAMP_UP: if (tick) begin
          speed_d = speed_up;
          if (speed_up == tgt_q) rev_d = RW'(REV_TICKS);
        end
        S_RUN: if (tick) begin
          run_d = (run_q == 10'd0) ? 10'd0 : run_q - 10'd1;
          if (run_q > 10'd1 && agit_q) begin
            rev_d = (rev_q == '0) ? '0 : rev_q - RW'(1);
            if (rev_q <= RW'(1)) begin
              speed_d = 4'd0;
              hold_d  = HW'(PAUSE_TICKS);
            end
          end
        end
        S_PAUSE: if (tick) begin
          hold_d = hold_q - HW'(1);
          if (hold_q <= HW'(1)) dir_d = ~dir_q;
        end
        S_REBAL:     if (tick) hold_d = hold_q - HW'(1);
        S_RAMP_DOWN: if (tick) begin
          if (speed_q <= 4'd1) begin
            speed_d   = 4'd0;
            done_d    = 1'b1;
            aborted_d = abt_q;
          end else begin
            speed_d = speed_q - 4'd1;
          end
        end
        S_FAULT: speed_d = 4'd0;
        default: speed_d = 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_motor_sequencer.sv
// Bench for drum_motor_sequencer: a per-tick profile model for clean commands
// (directed and random), plus directed imbalance, door, abort, zero-command
// and reset scenarios.
module tb_drum_motor_sequencer;
  localparam int TD = 4, REV = 2, PAU = 1, REB = 2, MAXR = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 0, cmd_ready, cmd_agitate = 0, abort = 0, door_locked = 1;
  logic vibration = 0, fault_clr = 0;
  logic [3:0] cmd_speed = 0, motor_speed;
  logic [9:0] cmd_ticks = 0;
  logic motor_dir, busy, done, aborted, fault;
  int n_chk = 0, n_fail = 0;

  drum_motor_sequencer #(.TICK_DIV(TD), .REV_TICKS(REV), .PAUSE_TICKS(PAU),
                         .REBAL_TICKS(REB), .MAX_REBAL(MAXR)) dut (
    .clk(clk), .reset(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_speed_i(cmd_speed), .cmd_ticks_i(cmd_ticks), .cmd_agitate_i(cmd_agitate),
    .abort_i(abort), .door_locked_i(door_locked), .vibration_i(vibration),
    .fault_clr_i(fault_clr), .motor_speed_o(motor_speed), .motor_dir_o(motor_dir),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .fault_o(fault));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input int s, input int t, input bit a);
    @(negedge clk);
    cmd_speed = 4'(s); cmd_ticks = 10'(t); cmd_agitate = a; cmd_valid = 1;
    #1 chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_speed(input int v, input string tag);
    int c = 0;
    while (motor_speed !== 4'(v) && c < 300) begin @(negedge clk); c++; end
    chk(tag, motor_speed, v);
  endtask

  task automatic pulse(input int which);
    if (which == 0) vibration = 1; else fault_clr = 1;
    @(posedge clk);
    #1 vibration = 0; fault_clr = 0;
    @(negedge clk);
  endtask

  // Expected speed/dir after each tick, built from the phase rules:
  // ramp 1..S, hold segments (reversal = REV-1 ticks at S, then PAU+1 zero
  // ticks with dir flipping on the last one), final ramp S-1..0.
  task automatic run_model(input int s, input int t, input bit a);
    int sq[$]; bit dq[$]; bit d; int r; int n;
    d = 0; r = t;
    while (1) begin
      for (int i = 1; i <= s; i++) begin sq.push_back(i); dq.push_back(d); end
      if (a && r > REV) begin
        for (int i = 0; i < REV - 1; i++) begin sq.push_back(s); dq.push_back(d); end
        sq.push_back(0); dq.push_back(d);
        for (int i = 0; i < PAU - 1; i++) begin sq.push_back(0); dq.push_back(d); end
        d = ~d; sq.push_back(0); dq.push_back(d);
        r -= REV;
      end else begin
        for (int i = 0; i < r; i++) begin sq.push_back(s); dq.push_back(d); end
        break;
      end
    end
    for (int i = s - 1; i >= 0; i--) begin sq.push_back(i); dq.push_back(d); end
    n = sq.size();
    accept(s, t, a);
    for (int k = 1; k <= n; k++) begin
      wait_edges(TD);
      chk($sformatf("speed_s%0d_t%0d_a%0d_k%0d", s, t, a, k), motor_speed, sq[k-1]);
      chk($sformatf("dir_s%0d_t%0d_a%0d_k%0d", s, t, a, k), motor_dir, dq[k-1]);
      chk($sformatf("busy_k%0d", k), busy, (k < n) ? 1 : 0);
      chk($sformatf("done_k%0d", k), done, (k == n) ? 1 : 0);
    end
    wait_edges(1);
    chk("done_single_pulse", done, 0);
    chk("aborted_clean_end", aborted, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_speed", motor_speed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_done", done, 0);
    reset = 0;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);

    // test 1: basic profile latency, then per-tick shape
    accept(3, 5, 0);
    c = 0;
    while (c < 200) begin @(negedge clk); c++; if (done === 1'b1) break; end
    chk("t1_done_latency", c, 45);
    wait_edges(2);
    run_model(3, 5, 0);

    // test 2: agitation
    run_model(1, 4, 1);

    // random clean commands
    for (int i = 0; i < 6; i++)
      run_model($urandom_range(1, 6), $urandom_range(1, 7), 1'($urandom_range(0, 1)));

    // test 3: imbalance, two rebalances then fault
    accept(5, 20, 0);
    for (int p = 0; p < 2; p++) begin
      wait_speed(5, "t3_reach5");
      pulse(0);
      chk("t3_rebal_speed", motor_speed, 1);
      chk("t3_rebal_fault", fault, 0);
    end
    wait_speed(5, "t3_reach5_last");
    pulse(0);
    chk("t3_fault", fault, 1);
    chk("t3_fault_speed", motor_speed, 0);
    chk("t3_fault_ready", cmd_ready, 0);
    chk("t3_fault_busy", busy, 1);
    pulse(1);
    chk("t3_clr_fault", fault, 0);
    chk("t3_clr_busy", busy, 0);
    chk("t3_clr_done", done, 0);
    chk("t3_clr_ready", cmd_ready, 1);

    // test 4: door drop mid-RUN
    accept(4, 20, 0);
    wait_speed(4, "t4_reach4");
    door_locked = 0;
    @(negedge clk);
    chk("t4_speed0", motor_speed, 0);
    chk("t4_fault", fault, 1);
    pulse(1);
    chk("t4_clr_fault", fault, 0);
    chk("t4_clr_busy", busy, 0);
    chk("t4_clr_done", done, 0);
    chk("t4_ready_door_open", cmd_ready, 0);
    door_locked = 1;
    #1 chk("t4_ready_door_locked", cmd_ready, 1);

    // test 5: abort in RAMP_UP at speed 2
    accept(5, 5, 0);
    wait_edges(2 * TD);
    chk("t5_speed2", motor_speed, 2);
    abort = 1;
    wait_edges(1);
    chk("t5_hold_speed", motor_speed, 2);
    wait_edges(TD - 1);
    chk("t5_down1", motor_speed, 1);
    chk("t5_no_done_yet", done, 0);
    wait_edges(TD);
    chk("t5_down0", motor_speed, 0);
    chk("t5_done", done, 1);
    chk("t5_aborted", aborted, 1);
    wait_edges(1);
    chk("t5_idle_done", done, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_ready", cmd_ready, 1);
    wait_edges(TD);
    chk("t5_idle_abort_speed", motor_speed, 0);
    abort = 0;

    // test 6: zero command, then reset mid-RAMP_UP
    accept(7, 0, 0);
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    chk("t6_speed", motor_speed, 0);
    wait_edges(1);
    chk("t6_done_cleared", done, 0);
    accept(5, 5, 1);
    wait_edges(2 * TD);
    chk("t6_ramp_speed", motor_speed, 2);
    #2 reset = 1;
    #1;
    chk("t6_rst_speed", motor_speed, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_fault", fault, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("t6_after_rst_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
